// File: rtl/video_capture_pkg.sv
// Shared types for the video capture path: FSM state, RGB565 pixel and FIFO entry.
package video_capture_pkg;

  // Widest write address a FIFO entry can carry; the top's ADDR_W must not exceed it.
  localparam int unsigned ENTRY_ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    rgb565_t                 data;
  } fifo_entry_t;

  function automatic rgb565_t pack565(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module capture_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count_n;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_comb begin
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + CW'(1);
    else if (!do_push && do_pop)
      count_n = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_n;
      empty <= (count_n == CW'(0));
      full  <= (count_n == CW'(DEPTH));
    end
  end

  // Storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/video_capture.sv
// Video sink: frame/line recovery from blanking, RGB565 packing, FIFO and req/ack write port.
// Define VIDEO_CAPTURE_CROP_EN to add a crop window (crop_x0/y0/w/h) sampled at frame start.
module video_capture
  import video_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              hblank,
  input  logic              vblank,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
`ifdef VIDEO_CAPTURE_CROP_EN
  input  logic [8:0]        crop_x0,
  input  logic [8:0]        crop_y0,
  input  logic [8:0]        crop_w,
  input  logic [8:0]        crop_h,
`endif
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ack,
  output logic              frame_done,
  output logic [8:0]        active_w,
  output logic [8:0]        active_h,
  output logic              overflow,
  output logic              busy
);

  state_t                       state;
  logic                         hbl_q, vbl_q;
  logic [ADDR_W-1:0]            addr, addr_c;
  logic [8:0]                   x, y, last_x, x_c, y_c;
  logic                         pix_push;
  fifo_entry_t                  pix_entry;
  fifo_entry_t                  head;
  logic                         fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fs_c, fe_c, le_c, start_c, cap_c, win_c, pop_c;
  logic                         unused_bits;

`ifdef VIDEO_CAPTURE_CROP_EN
  logic [8:0] crop_x0_q, crop_y0_q, crop_w_q, crop_h_q;
  logic [8:0] cx0, cy0, cw, ch;
`endif

  // Edge detection and the coordinates the current pixel would use (reset to origin on a starting FS).
  always_comb begin
    fs_c    = ce_pix & vbl_q & ~vblank;
    fe_c    = ce_pix & ~vbl_q & vblank;
    le_c    = ce_pix & ~hbl_q & hblank;
    start_c = (state == WAIT_FS) & fs_c & enable;
    cap_c   = ce_pix & ~hblank & ~vblank & ((state == CAPTURE) | start_c);
    addr_c  = start_c ? '0 : addr;
    x_c     = start_c ? '0 : x;
    y_c     = start_c ? '0 : y;
    pop_c   = wr_ack & ~fifo_empty;
    win_c   = 1'b1;
`ifdef VIDEO_CAPTURE_CROP_EN
    cx0   = start_c ? crop_x0 : crop_x0_q;
    cy0   = start_c ? crop_y0 : crop_y0_q;
    cw    = start_c ? crop_w  : crop_w_q;
    ch    = start_c ? crop_h  : crop_h_q;
    win_c = (x_c >= cx0) && ({1'b0, x_c} < (10'(cx0) + 10'(cw))) &&
            (y_c >= cy0) && ({1'b0, y_c} < (10'(cy0) + 10'(ch)));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hbl_q      <= 1'b1;
      vbl_q      <= 1'b1;
      addr       <= '0;
      x          <= '0;
      y          <= '0;
      last_x     <= '0;
      pix_push   <= 1'b0;
      pix_entry  <= '0;
      frame_done <= 1'b0;
      active_w   <= '0;
      active_h   <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
`ifdef VIDEO_CAPTURE_CROP_EN
      crop_x0_q  <= '0;
      crop_y0_q  <= '0;
      crop_w_q   <= '0;
      crop_h_q   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      pix_push   <= 1'b0;
      if (ce_pix) begin
        hbl_q <= hblank;
        vbl_q <= vblank;
      end
      if (pix_push && fifo_full && !pop_c)
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT_FS;
            busy  <= 1'b1;
          end
        end
        WAIT_FS: begin
          if (fs_c) begin
            if (enable) begin
              state    <= CAPTURE;
              addr     <= '0;
              x        <= '0;
              y        <= '0;
              last_x   <= '0;
              overflow <= 1'b0;
`ifdef VIDEO_CAPTURE_CROP_EN
              crop_x0_q <= crop_x0;
              crop_y0_q <= crop_y0;
              crop_w_q  <= crop_w;
              crop_h_q  <= crop_h;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (le_c && x != 9'd0) begin
            last_x <= x;
            y      <= y + 9'd1;
            x      <= '0;
          end
          // A line still open at frame end counts as a line.
          if (fe_c) begin
            state <= DRAIN;
            if (le_c && x != 9'd0) begin
              active_w <= x;
              active_h <= y + 9'd1;
            end else begin
              active_w <= last_x;
              active_h <= y + 9'(x != 9'd0);
            end
          end
        end
        DRAIN: begin
          if (fifo_empty && !pix_push) begin
            state      <= WAIT_FS;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Pixel stage: the address advances whether or not the FIFO accepts the pixel.
      if (cap_c) begin
        x <= x_c + 9'd1;
        if (win_c) begin
          pix_push  <= 1'b1;
          pix_entry <= '{addr: ENTRY_ADDR_W'(addr_c), data: pack565(r, g, b)};
          addr      <= addr_c + ADDR_W'(1);
        end
      end
    end
  end

  capture_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fifo_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pix_push),
    .push_data (pix_entry),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_req  = ~fifo_empty;
  assign wr_addr = fifo_empty ? '0 : ADDR_W'(head.addr);
  assign wr_data = fifo_empty ? '0 : head.data;

  assign unused_bits = ^{hsync, vsync, head.addr, fifo_count};

endmodule

// File: tb/tb_video_capture.sv
// Directed self-checking bench for video_capture using scaled-down video timings.
module tb_video_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ce_pix;
  logic        hsync, vsync, hblank, vblank;
  logic [7:0]  r, g, b;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        frame_done;
  logic [8:0]  active_w, active_h;
  logic        overflow;
  logic        busy;
`ifdef VIDEO_CAPTURE_CROP_EN
  logic [8:0]  crop_x0, crop_y0, crop_w, crop_h;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  int last_wr_cyc = 0;
  logic [16:0] wa[$];
  logic [15:0] wd[$];
  bit          fixed = 1'b0;
  logic [7:0]  fix_r, fix_g, fix_b;

  video_capture dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ce_pix     (ce_pix),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .r          (r),
    .g          (g),
    .b          (b),
`ifdef VIDEO_CAPTURE_CROP_EN
    .crop_x0    (crop_x0),
    .crop_y0    (crop_y0),
    .crop_w     (crop_w),
    .crop_h     (crop_h),
`endif
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .frame_done (frame_done),
    .active_w   (active_w),
    .active_h   (active_h),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log accepted writes and frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_req === 1'b1 && wr_ack === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      last_wr_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  function automatic logic [15:0] exp565(input int px, input int py);
    return {5'(px), 6'(py), 5'(px + py)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input bit hb, input bit vb, input int px, input int py, input int div);
    ce_pix = 1'b1;
    hblank = hb;
    vblank = vb;
    hsync  = hb;
    vsync  = vb;
    if (fixed) begin
      r = fix_r; g = fix_g; b = fix_b;
    end else begin
      r = {5'(px), 3'b000};
      g = {6'(py), 2'b00};
      b = {5'(px + py), 3'b000};
    end
    tick();
    ce_pix = 1'b0;
    for (int i = 1; i < div; i++) tick();
  endtask

  task automatic line(input int ly, input bit vb, input int aw, input int tw, input int div);
    for (int px = 0; px < tw; px++) pix(px >= aw, vb, px, ly, div);
  endtask

  task automatic blank_lines(input int n, input int aw, input int tw, input int div);
    for (int l = 0; l < n; l++) line(0, 1'b1, aw, tw, div);
  endtask

  task automatic frame(input int aw, input int ah, input int tw, input int vbn, input int div);
    blank_lines(vbn, aw, tw, div);
    for (int ly = 0; ly < ah; ly++) line(ly, 1'b0, aw, tw, div);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic wait_fd(input int fdc0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fd_cnt != fdc0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL rst_wr_req got %b want 0", wr_req); end
    total++; if (wr_addr !== 17'd0) begin bad++; $display("FAIL rst_wr_addr got %0h want 0", wr_addr); end
    total++; if (wr_data !== 16'd0) begin bad++; $display("FAIL rst_wr_data got %0h want 0", wr_data); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    total++; if (active_w !== 9'd0 || active_h !== 9'd0) begin bad++; $display("FAIL rst_active got %0d/%0d want 0/0", active_w, active_h); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got %b want 0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    reset = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_frame();
    int fdc0, errs;
    clear_log();
    fdc0 = fd_cnt;
    enable = 1'b1;
    wr_ack = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arm_busy got %b want 1", busy); end
    frame(32, 24, 40, 4, 4);
    blank_lines(4, 32, 40, 4);
    wait_fd(fdc0, 200);
    total++; if (wa.size() !== 768) begin bad++; $display("FAIL frame_writes got %0d want 768", wa.size()); end
    errs = 0;
    for (int i = 0; i < wa.size() && i < 768; i++)
      if (wa[i] !== 17'(i) || wd[i] !== exp565(i % 32, i / 32)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL frame_order got %0d bad entries want 0", errs); end
    total++; if (active_w !== 9'd32) begin bad++; $display("FAIL frame_w got %0d want 32", active_w); end
    total++; if (active_h !== 9'd24) begin bad++; $display("FAIL frame_h got %0d want 24", active_h); end
    total++; if (fd_cnt - fdc0 !== 1) begin bad++; $display("FAIL frame_done_cnt got %0d want 1", fd_cnt - fdc0); end
    total++; if (!(fd_cyc > last_wr_cyc)) begin bad++; $display("FAIL done_after_write got done@%0d last@%0d", fd_cyc, last_wr_cyc); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL frame_overflow got %b want 0", overflow); end
  endtask

  task automatic test_pack();
    int fdc0;
    clear_log();
    wr_ack = 1'b0;
    fixed = 1'b1; fix_r = 8'hFF; fix_g = 8'h80; fix_b = 8'h08;
    blank_lines(2, 1, 4, 1);
    fdc0 = fd_cnt;
    pix(1'b0, 1'b0, 0, 0, 1);
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL lat_n1 got %b want 0", wr_req); end
    pix(1'b1, 1'b0, 1, 0, 1);
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL lat_n2 got %b want 1", wr_req); end
    total++; if (wr_data !== 16'hFC01) begin bad++; $display("FAIL pack565 got %h want fc01", wr_data); end
    total++; if (wr_addr !== 17'd0) begin bad++; $display("FAIL pack_addr got %0h want 0", wr_addr); end
    pix(1'b1, 1'b0, 2, 0, 1);
    pix(1'b1, 1'b0, 3, 0, 1);
    blank_lines(1, 1, 4, 1);
    total++; if (wr_data !== 16'hFC01 || wr_req !== 1'b1) begin bad++; $display("FAIL hold got %b/%h want 1/fc01", wr_req, wr_data); end
    total++; if (fd_cnt !== fdc0) begin bad++; $display("FAIL early_done got %0d want %0d", fd_cnt, fdc0); end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    wait_fd(fdc0, 20);
    total++; if (wa.size() !== 1) begin bad++; $display("FAIL pack_writes got %0d want 1", wa.size()); end
    total++; if (active_w !== 9'd1 || active_h !== 9'd1) begin bad++; $display("FAIL pack_dim got %0d/%0d want 1/1", active_w, active_h); end
    total++; if (fd_cnt - fdc0 !== 1) begin bad++; $display("FAIL pack_done got %0d want 1", fd_cnt - fdc0); end
    fixed = 1'b0;
  endtask

  task automatic test_overflow();
    int fdc0, errs;
    clear_log();
    wr_ack = 1'b0;
    fdc0 = fd_cnt;
    frame(20, 2, 24, 2, 1);
    blank_lines(1, 20, 24, 1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got %b want 1", overflow); end
    wr_ack = 1'b1;
    wait_fd(fdc0, 100);
    total++; if (wa.size() !== 16) begin bad++; $display("FAIL ovf_kept got %0d want 16", wa.size()); end
    errs = 0;
    for (int i = 0; i < wa.size() && i < 16; i++)
      if (wa[i] !== 17'(i) || wd[i] !== exp565(i, 0)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL ovf_entries got %0d bad want 0", errs); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clear_log();
    fdc0 = fd_cnt;
    frame(20, 2, 24, 2, 1);
    blank_lines(1, 20, 24, 1);
    wait_fd(fdc0, 100);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b want 0", overflow); end
    total++; if (wa.size() !== 40) begin bad++; $display("FAIL ovf_next_writes got %0d want 40", wa.size()); end
  endtask

  task automatic test_late_enable();
    int fdc0, errs;
    clear_log();
    enable = 1'b0;
    wr_ack = 1'b1;
    fdc0 = fd_cnt;
    blank_lines(2, 8, 12, 1);
    line(0, 1'b0, 8, 12, 1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL late_idle got %b want 0", busy); end
    enable = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL late_arm got %b want 1", busy); end
    for (int ly = 1; ly < 4; ly++) line(ly, 1'b0, 8, 12, 1);
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL late_early_write got %0d want 0", wa.size()); end
    frame(8, 4, 12, 2, 1);
    blank_lines(1, 8, 12, 1);
    wait_fd(fdc0, 100);
    total++; if (wa.size() !== 32) begin bad++; $display("FAIL late_writes got %0d want 32", wa.size()); end
    errs = 0;
    for (int i = 0; i < wa.size() && i < 32; i++)
      if (wa[i] !== 17'(i) || wd[i] !== exp565(i % 8, i / 8)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL late_order got %0d bad want 0", errs); end
    total++; if (fd_cnt - fdc0 !== 1) begin bad++; $display("FAIL late_done got %0d want 1", fd_cnt - fdc0); end
  endtask

  task automatic test_reset_midframe();
    int fdc0;
    clear_log();
    enable = 1'b1;
    wr_ack = 1'b0;
    blank_lines(2, 12, 16, 1);
    for (int px = 0; px < 10; px++) pix(1'b0, 1'b0, px, 0, 1);
    pix(1'b1, 1'b0, 10, 0, 1);
    pix(1'b1, 1'b0, 11, 0, 1);
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL mid_pre_req got %b want 1", wr_req); end
    fdc0 = fd_cnt;
    reset = 1'b1;
    tick();
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got %b want 0", wr_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    reset = 1'b0;
    hblank = 1'b1;
    vblank = 1'b1;
    repeat (5) tick();
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL mid_flush got %b want 0", wr_req); end
    total++; if (fd_cnt !== fdc0) begin bad++; $display("FAIL mid_no_done got %0d want %0d", fd_cnt, fdc0); end
  endtask

`ifdef VIDEO_CAPTURE_CROP_EN
  task automatic test_crop();
    int fdc0, errs;
    clear_log();
    enable = 1'b1;
    wr_ack = 1'b1;
    crop_x0 = 9'd4; crop_y0 = 9'd3; crop_w = 9'd20; crop_h = 9'd16;
    fdc0 = fd_cnt;
    frame(32, 24, 40, 2, 1);
    blank_lines(1, 32, 40, 1);
    wait_fd(fdc0, 100);
    total++; if (wa.size() !== 320) begin bad++; $display("FAIL crop_writes got %0d want 320", wa.size()); end
    errs = 0;
    for (int i = 0; i < wa.size() && i < 320; i++)
      if (wa[i] !== 17'(i) || wd[i] !== exp565(4 + i % 20, 3 + i / 20)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL crop_order got %0d bad want 0", errs); end
    if (wa.size() >= 21) begin
      total++; if (wd[0] !== exp565(4, 3)) begin bad++; $display("FAIL crop_first got %h want %h", wd[0], exp565(4, 3)); end
      total++; if (wd[19] !== exp565(23, 3)) begin bad++; $display("FAIL crop_row_end got %h want %h", wd[19], exp565(23, 3)); end
    end
    total++; if (active_w !== 9'd32 || active_h !== 9'd24) begin bad++; $display("FAIL crop_dim got %0d/%0d want 32/24", active_w, active_h); end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; ce_pix = 1'b0; wr_ack = 1'b0;
    hsync = 1'b0; vsync = 1'b1; hblank = 1'b1; vblank = 1'b1;
    r = 8'd0; g = 8'd0; b = 8'd0;
    fix_r = 8'd0; fix_g = 8'd0; fix_b = 8'd0;
`ifdef VIDEO_CAPTURE_CROP_EN
    crop_x0 = 9'd0; crop_y0 = 9'd0; crop_w = 9'd0; crop_h = 9'd0;
`endif
    test_reset();
    test_frame();
    test_pack();
    test_overflow();
    test_late_enable();
    test_reset_midframe();
`ifdef VIDEO_CAPTURE_CROP_EN
    test_crop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_capture.md
Name: video_capture

Overview:
- Sink end of the core's pixel video interface: ce_pix, HSync/VSync/HBlank/VBlank and 8-bit RGB.
- Recovers frame and line structure from the blanking signals.
- Packs active pixels to RGB565 and buffers them in a small FIFO.
- Drains them to a framebuffer or scaler memory over a req/ack write port.
- Also reports the measured active width and height per frame.

Parameters:
- FIFO_DEPTH, 16, entries in the pixel FIFO (power of two, ≥4).
- ADDR_W, 17, width of the linear write address.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- enable  in  1  arm capture; sampled only at frame start.
- ce_pix  in  1  pixel strobe; all video inputs are sampled only when high.
- hsync  in  1  horizontal sync (monitored, not required for capture).
- vsync  in  1  vertical sync (monitored, not required for capture).
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- r, g, b  in  8 each  pixel colour.
- wr_req  out  1  write request.
- wr_addr  out  ADDR_W  linear pixel address from frame origin.
- wr_data  out  16  RGB565 pixel.
- wr_ack  in  1  write accepted this cycle.
- frame_done  out  1  one-cycle pulse when the frame is fully written.
- active_w  out  9  active pixels on the last line of the last frame.
- active_h  out  9  active lines of the last frame.
- overflow  out  1  sticky flag: a pixel was dropped this frame.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FIFO is empty; state is IDLE.
  - Edge registers (hbl_q, vbl_q) are 1.
- Sampling and edges:
  - On ce_pix=1, register hbl_q<=hblank and vbl_q<=vblank.
  - Frame start (FS) = vblank 1→0 at a ce_pix sample.
  - Frame end (FE) = vblank 0→1.
  - Line end (LE) = hblank 0→1.
  - Active pixel = ce_pix & ~hblank & ~vblank.
- States:
  - IDLE → WAIT_FS when enable=1.
  - WAIT_FS → CAPTURE on FS, if enable is still 1; else → IDLE.
  - CAPTURE → DRAIN on FE.
  - DRAIN → WAIT_FS when the FIFO is empty and no write is outstanding. frame_done pulses in the same cycle.
  - Asserting enable mid-frame never starts capture before the next FS.
  - Deasserting enable during CAPTURE takes effect only after DRAIN.
- On FS:
  - addr counter, x and y are cleared to 0.
  - overflow is cleared.
- In CAPTURE, each active pixel:
  - pushes {addr, pack565};
  - increments addr (wraps modulo 2^ADDR_W) and x;
  - addr advances even if the pixel is dropped.
- On LE with x>0:
  - last_x <= x; y <= y+1; x <= 0.
- On FE:
  - active_w <= last_x, active_h <= y.
  - An incomplete line (x>0 at FE) counts as a line.
- pack565 = {r[7:3], g[7:2], b[7:3]}.
- FIFO:
  - A push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the pixel is dropped and overflow<=1.
- Write port:
  - wr_req=1 whenever the FIFO head is valid; wr_addr/wr_data show the head.
  - They are held stable until wr_ack.
  - wr_ack with wr_req=1 pops the head; the next head is presented in the following cycle.
  - wr_ack with wr_req=0 is ignored.
- Latency: pixel sampled in cycle N appears on wr_req/wr_data at cycle N+2 at the earliest (empty FIFO).
- Reset at any time, including mid-frame with wr_req high:
  - wr_req=0 in the next cycle.
  - FIFO is flushed; no frame_done.

Optional Feature:
- VIDEO_CAPTURE_CROP_EN defined:
  - Adds inputs crop_x0[8:0], crop_y0[8:0], crop_w[8:0], crop_h[8:0], sampled at FS.
  - Only active pixels with crop_x0≤x<crop_x0+crop_w and crop_y0≤y<crop_y0+crop_h are pushed.
  - addr counts only the pixels that are pushed, so the first in-window pixel gets addr 0.
  - active_w/active_h still report the uncropped dimensions.
- Undefined: these ports are absent and every active pixel is captured.

Decomposition:
- Package video_capture_pkg:
  - state enum (IDLE, WAIT_FS, CAPTURE, DRAIN);
  - rgb565_t;
  - fifo entry struct {addr, data};
  - function pack565.
- One sub-module, capture_fifo:
  - synchronous, parameterised by depth and entry type;
  - push/pop/full/empty/count;
  - same-cycle push+pop when full is allowed.

Test Plan:
- 256×240 frame, 341×262 timing, ce_pix every 4 clk, wr_ack=1 → 61440 writes, addr 0..61439 in order, active_w=256, active_h=240, exactly one frame_done after the last write.
- Single pixel r=8'hFF, g=8'h80, b=8'h08 → wr_data=16'hFC01.
- ce_pix every clk, wr_ack=0 for 40 cycles, FIFO_DEPTH=16 → 17th pixel dropped, overflow=1, retained entries keep correct addresses, overflow=0 after next FS.
- enable rises mid-CAPTURE-window from IDLE → zero writes until next vblank 1→0, then capture starts at addr 0.
- reset asserted while wr_req=1 with 10 entries queued → wr_req=0 next cycle, busy=0, no frame_done.
- CROP_EN, x0=8, y0=8, w=240, h=224 → 53760 writes, addr 0 carries source pixel (8,8), addr 239 carries (247,8).
